// File: rtl/std_sram_singleport_arbiter_if.sv
// std_sram_singleport_arbiter_if: one requester's request/grant/read-return bundle
interface std_sram_singleport_arbiter_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
);
  logic req;
  logic we;
  logic lock;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master(output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/std_sram_singleport_arbiter.sv
// std_sram_singleport_arbiter: two-port round-robin/lock arbiter over one single-port SRAM
// Define STD_SRAM_ARBITER_FIXED_PRIORITY_EN to make port 0 win every tie.
module std_sram_singleport #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else dout <= mem[addr];
    end
  end
endmodule

module std_sram_singleport_arbiter #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input logic clk,
  input logic resetn,
  std_sram_singleport_arbiter_if.slave p0,
  std_sram_singleport_arbiter_if.slave p1
);
  typedef enum logic [1:0] {NONE, OWN0, OWN1} lock_t;
  lock_t lock_q, lock_d;
  logic last_gnt;
  logic sel1;
  logic [1:0] rv_q;
  logic [DATA_WIDTH-1:0] hold0, hold1, dout;
  logic en, we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  // sel1: which port wins when both request; a held lock overrides the tie-break
  always_comb begin
`ifdef STD_SRAM_ARBITER_FIXED_PRIORITY_EN
    sel1 = (lock_q == OWN1) && p1.req;
`else
    sel1 = ((lock_q == OWN1) && p1.req) ? 1'b1 :
           ((lock_q == OWN0) && p0.req) ? 1'b0 : !last_gnt;
`endif
  end
  assign p0.gnt = resetn & p0.req & !(p1.req & sel1);
  assign p1.gnt = resetn & p1.req & !(p0.req & !sel1);
  always_comb begin
    lock_d = NONE;
    lock_d = (p0.gnt && p0.lock) ? OWN0 : (p1.gnt && p1.lock) ? OWN1 : NONE;
  end
  assign en   = p0.gnt | p1.gnt;
  assign we   = p1.gnt ? p1.we : p0.we;
  assign addr = p1.gnt ? p1.addr : p0.addr;
  assign din  = p1.gnt ? p1.wdata : p0.wdata;
  std_sram_singleport #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sram (
    .clk(clk), .en(en), .we(we), .addr(addr), .din(din), .dout(dout)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q   <= NONE;
      last_gnt <= 1'b1;
      rv_q     <= '0;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      lock_q <= lock_d;
      if (en) last_gnt <= p1.gnt;
      rv_q <= {p1.gnt & !p1.we, p0.gnt & !p0.we};
      if (rv_q[0]) hold0 <= dout;
      if (rv_q[1]) hold1 <= dout;
    end
  end
  // dout is shared, so each port shows it only in its own response cycle and its hold copy otherwise
  assign p0.rvalid = rv_q[0];
  assign p1.rvalid = rv_q[1];
  assign p0.rdata  = rv_q[0] ? dout : hold0;
  assign p1.rdata  = rv_q[1] ? dout : hold1;
endmodule

// File: tb/tb_std_sram_singleport_arbiter.sv
// tb_std_sram_singleport_arbiter: directed checks of arbitration, lock, read return and reset
module tb_std_sram_singleport_arbiter;
  logic clk = 0;
  logic resetn;
  int checks = 0;
  int failures = 0;
  std_sram_singleport_arbiter_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) p0_if ();
  std_sram_singleport_arbiter_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) p1_if ();
  std_sram_singleport_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .p0(p0_if.slave), .p1(p1_if.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int p, input logic req, input logic we, input logic lock,
                     input logic [2:0] addr, input logic [7:0] wdata);
    if (p == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.lock = lock; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.lock = lock; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 0;
    drv(0, 1, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0);
    step(); step();
    #1;
    chk("rst_p0_gnt", p0_if.gnt, 0);
    chk("rst_p1_gnt", p1_if.gnt, 0);
    chk("rst_p0_rvalid", p0_if.rvalid, 0);
    chk("rst_p1_rvalid", p1_if.rvalid, 0);
    chk("rst_p0_rdata", p0_if.rdata, 0);
    chk("rst_p1_rdata", p1_if.rdata, 0);
    resetn = 1;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    // 1: write then read on port 0
    step();
    drv(0, 1, 1, 0, 3, 8'hA5);
    #1 chk("t1_wr_gnt", p0_if.gnt, 1);
    step();
    drv(0, 1, 0, 0, 3, 0);
    #1 chk("t1_rd_gnt", p0_if.gnt, 1);
    chk("t1_wr_no_rvalid", p0_if.rvalid, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("t1_rvalid", p0_if.rvalid, 1);
    chk("t1_rdata", p0_if.rdata, 8'hA5);
    step();
    chk("t1_rvalid_drop", p0_if.rvalid, 0);
    chk("t1_rdata_hold", p0_if.rdata, 8'hA5);
    // seed port 1 data: addr 5 = 0x5A
    drv(1, 1, 1, 0, 5, 8'h5A);
    step();
    // 2: both read every cycle, last_gnt=1 so port 0 first
    drv(0, 1, 0, 0, 3, 0);
    drv(1, 1, 0, 0, 5, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_p0_gnt%0d", i), p0_if.gnt, (i % 2 == 0));
      chk($sformatf("t2_p1_gnt%0d", i), p1_if.gnt, (i % 2 == 1));
      if (i > 0) begin
        chk($sformatf("t2_p0_rv%0d", i), p0_if.rvalid, (i % 2 == 1));
        chk($sformatf("t2_p1_rv%0d", i), p1_if.rvalid, (i % 2 == 0));
        chk($sformatf("t2_p0_rd%0d", i), p0_if.rdata, 8'hA5);
        chk($sformatf("t2_p1_rd%0d", i), p1_if.rdata, (i == 1) ? 8'h00 : 8'h5A);
      end
      step();
    end
    chk("t2_p1_rv_last", p1_if.rvalid, 1);
    chk("t2_p1_rd_last", p1_if.rdata, 8'h5A);
    // 3: p1 locks for 4 cycles; p0 requests from cycle 2 on
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 1, 5, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_p1_gnt%0d", i), p1_if.gnt, 1);
      chk($sformatf("t3_p0_gnt%0d", i), p0_if.gnt, 0);
      step();
      drv(0, 1, 0, 0, 3, 0);
    end
    drv(1, 0, 0, 0, 0, 0);
    #1 chk("t3_p0_gnt_c5", p0_if.gnt, 1);
    chk("t3_p1_gnt_c5", p1_if.gnt, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    // 4: p1 write 7=0x3C, then p0 read 7
    drv(1, 1, 1, 0, 7, 8'h3C);
    step();
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 7, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("t4_p0_rvalid", p0_if.rvalid, 1);
    chk("t4_p0_rdata", p0_if.rdata, 8'h3C);
    chk("t4_p1_rvalid", p1_if.rvalid, 0);
    chk("t4_p1_rdata", p1_if.rdata, 8'h5A);
    // 5: reset lands right after a granted read
    step();
    drv(0, 1, 0, 0, 7, 0);
    #1 chk("t5_gnt", p0_if.gnt, 1);
    resetn = 0;
    step();
    chk("t5_rvalid", p0_if.rvalid, 0);
    chk("t5_rdata", p0_if.rdata, 0);
    chk("t5_gnt_in_rst", p0_if.gnt, 0);
    resetn = 1;
    drv(0, 0, 0, 0, 0, 0);
    step();
    // 6: both request for 3 cycles after reset
    drv(0, 1, 0, 0, 7, 0);
    drv(1, 1, 0, 0, 5, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef STD_SRAM_ARBITER_FIXED_PRIORITY_EN
      chk($sformatf("t6_p0_gnt%0d", i), p0_if.gnt, 1);
      chk($sformatf("t6_p1_gnt%0d", i), p1_if.gnt, 0);
`else
      chk($sformatf("t6_p0_gnt%0d", i), p0_if.gnt, (i != 1));
      chk($sformatf("t6_p1_gnt%0d", i), p1_if.gnt, (i == 1));
`endif
      step();
      if (i == 0) chk("t6_sram_kept", p0_if.rdata, 8'h3C);
    end
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
